// File: rtl/al_accel_bpbuf_fifo.sv
// al_accel_bpbuf_fifo
//   DEPTH-entry, DATA_W-wide circular bypass buffer between an accelerator
//   stage producer and its consumer. While empty, the head output shows a
//   programmable init word. Occupancy/status flags are decoded from the
//   count, and overflow/underflow errors are sticky until clr or reset.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        synchronous active-high reset (clears state and the array)
//   enb          stall enable; when low, push/pop are ignored
//   clr          synchronous flush of pointers, count and error flags
//   bpbuf_di     push data
//   bpbuf_push   load strobe (write at tail)
//   bpbuf_pop    drain strobe (discard head)
//   bpbuf_init   word presented on bpbuf_do while empty
//   bpbuf_do     head entry, or bpbuf_init when empty
//   bpbuf_vld    head valid (count != 0)
//   bpbuf_full   count == DEPTH
//   bpbuf_empty  count == 0
//   bpbuf_cnt    current occupancy
//   bpbuf_ovf    sticky overflow error
//   bpbuf_udf    sticky underflow error
module al_accel_bpbuf_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic              clr,
  input  logic [DATA_W-1:0] bpbuf_di,
  input  logic              bpbuf_push,
  input  logic              bpbuf_pop,
  input  logic [DATA_W-1:0] bpbuf_init,
  output logic [DATA_W-1:0] bpbuf_do,
  output logic              bpbuf_vld,
  output logic              bpbuf_full,
  output logic              bpbuf_empty,
  output logic [CNT_W-1:0]  bpbuf_cnt,
  output logic              bpbuf_ovf,
  output logic              bpbuf_udf
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [PTR_W-1:0]  rp_q, rp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic full, empty, push_ok, pop_ok;

  // Explicit wrap so non-power-of-two depths stay within 0..DEPTH-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);

  // A pop on empty is never accepted, so push+pop on empty only pushes.
  // At full, a simultaneous pop frees the head slot for the incoming word.
  assign pop_ok  = enb & bpbuf_pop & ~empty;
  assign push_ok = enb & bpbuf_push & (~full | pop_ok);

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (clr) begin
      // Flush wins over any strobe this cycle; array contents are kept.
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (push_ok) begin
        mem_d[wp_q] = bpbuf_di;
        wp_d        = ptr_inc(wp_q);
      end
      if (pop_ok) begin
        rp_d = ptr_inc(rp_q);
      end
      if (push_ok && !pop_ok) begin
        cnt_d = cnt_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        cnt_d = cnt_q - 1'b1;
      end
      if (enb && bpbuf_push && full && !bpbuf_pop) begin
        ovf_d = 1'b1;
      end
      if (enb && bpbuf_pop && empty) begin
        udf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Combinational head mux so an init change while empty shows immediately.
  assign bpbuf_do    = empty ? bpbuf_init : mem_q[rp_q];
  assign bpbuf_vld   = ~empty;
  assign bpbuf_full  = full;
  assign bpbuf_empty = empty;
  assign bpbuf_cnt   = cnt_q;
  assign bpbuf_ovf   = ovf_q;
  assign bpbuf_udf   = udf_q;

endmodule

// File: tb/tb_al_accel_bpbuf_fifo.sv
// Self-checking bench for al_accel_bpbuf_fifo: a DEPTH=4 instance driven by
// a directed vector table, and a DEPTH=3 instance exercising pointer wrap.
module tb_al_accel_bpbuf_fifo;

  localparam logic [31:0] INIT = 32'h12345678;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] init;

  // DEPTH=4 instance
  logic        a_enb, a_clr, a_push, a_pop;
  logic [31:0] a_di, a_do;
  logic        a_vld, a_full, a_empty, a_ovf, a_udf;
  logic [2:0]  a_cnt;

  // DEPTH=3 instance
  logic        b_enb, b_clr, b_push, b_pop;
  logic [31:0] b_di, b_do;
  logic        b_vld, b_full, b_empty, b_ovf, b_udf;
  logic [1:0]  b_cnt;

  al_accel_bpbuf_fifo #(.DATA_W(32), .DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .enb(a_enb), .clr(a_clr),
    .bpbuf_di(a_di), .bpbuf_push(a_push), .bpbuf_pop(a_pop),
    .bpbuf_init(init), .bpbuf_do(a_do), .bpbuf_vld(a_vld),
    .bpbuf_full(a_full), .bpbuf_empty(a_empty), .bpbuf_cnt(a_cnt),
    .bpbuf_ovf(a_ovf), .bpbuf_udf(a_udf)
  );

  al_accel_bpbuf_fifo #(.DATA_W(32), .DEPTH(3)) u_b (
    .clk(clk), .reset(reset), .enb(b_enb), .clr(b_clr),
    .bpbuf_di(b_di), .bpbuf_push(b_push), .bpbuf_pop(b_pop),
    .bpbuf_init(init), .bpbuf_do(b_do), .bpbuf_vld(b_vld),
    .bpbuf_full(b_full), .bpbuf_empty(b_empty), .bpbuf_cnt(b_cnt),
    .bpbuf_ovf(b_ovf), .bpbuf_udf(b_udf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int cnt, input logic [31:0] dout,
                       input bit ovf, input bit udf);
    chk({tag, ".cnt"},   32'(a_cnt),   32'(cnt));
    chk({tag, ".do"},    a_do,         dout);
    chk({tag, ".empty"}, 32'(a_empty), 32'(cnt == 0));
    chk({tag, ".full"},  32'(a_full),  32'(cnt == 4));
    chk({tag, ".vld"},   32'(a_vld),   32'(cnt != 0));
    chk({tag, ".ovf"},   32'(a_ovf),   32'(ovf));
    chk({tag, ".udf"},   32'(a_udf),   32'(udf));
  endtask

  typedef struct {
    bit          enb, clr, push, pop;
    logic [31:0] di;
    int          cnt;
    logic [31:0] dout;
    bit          ovf, udf;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit enb, input bit clr, input bit push, input bit pop,
                     input logic [31:0] di, input int cnt, input logic [31:0] dout,
                     input bit ovf, input bit udf);
    vec_t v;
    v.enb = enb; v.clr = clr; v.push = push; v.pop = pop; v.di = di;
    v.cnt = cnt; v.dout = dout; v.ovf = ovf; v.udf = udf;
    vt.push_back(v);
  endtask

  // Reference queue for the DEPTH=3 wrap sequence.
  logic [31:0] q[$];

  task automatic step_b(input bit push, input bit pop, input logic [31:0] di);
    bit pe, pu;
    b_enb = 1'b1; b_push = push; b_pop = pop; b_di = di;
    @(posedge clk);
    #1;
    pe = pop && (q.size() != 0);
    pu = push && ((q.size() != 3) || pe);
    if (pe) void'(q.pop_front());
    if (pu) q.push_back(di);
    $display("b: push=%0d pop=%0d di=%h -> cnt=%0d do=%h", push, pop, di, b_cnt, b_do);
    chk("wrap.cnt",   32'(b_cnt),   32'(q.size()));
    chk("wrap.do",    b_do,         (q.size() != 0) ? q[0] : INIT);
    chk("wrap.full",  32'(b_full),  32'(q.size() == 3));
    chk("wrap.empty", 32'(b_empty), 32'(q.size() == 0));
    chk("wrap.err",   {30'b0, b_ovf, b_udf}, 32'd0);
    b_push = 1'b0; b_pop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; init = 32'hDEADBEEF;
    a_enb = 1'b0; a_clr = 1'b0; a_push = 1'b0; a_pop = 1'b0; a_di = '0;
    b_enb = 1'b0; b_clr = 1'b0; b_push = 1'b0; b_pop = 1'b0; b_di = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Load two words, then reset with a push pending: reset must win.
    a_enb = 1'b1; a_push = 1'b1; a_di = 32'hCAFE0001;
    repeat (2) @(posedge clk);
    #1;
    chk("prefill.cnt", 32'(a_cnt), 32'd2);
    reset = 1'b1; a_di = 32'hCAFE0002;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; a_push = 1'b0;
    $display("reset: cnt=%0d do=%h", a_cnt, a_do);
    chk_a("reset", 0, 32'hDEADBEEF, 1'b0, 1'b0);

    // Init word change while empty is visible without a clock edge.
    init = INIT;
    #1;
    chk("init_follow.do", a_do, INIT);

    // enb clr push pop di            cnt do     ovf udf
    add(1, 0, 1, 0, 32'h11,           1, 32'h11, 0, 0);
    add(1, 0, 1, 0, 32'h22,           2, 32'h11, 0, 0);
    add(1, 0, 1, 0, 32'h33,           3, 32'h11, 0, 0);
    add(1, 0, 1, 0, 32'h44,           4, 32'h11, 0, 0);
    add(1, 0, 0, 1, 32'h0,            3, 32'h22, 0, 0);
    add(1, 0, 0, 1, 32'h0,            2, 32'h33, 0, 0);
    add(1, 0, 0, 1, 32'h0,            1, 32'h44, 0, 0);
    add(1, 0, 0, 1, 32'h0,            0, INIT,   0, 0);
    add(1, 0, 1, 0, 32'h11,           1, 32'h11, 0, 0);
    add(1, 0, 1, 0, 32'h22,           2, 32'h11, 0, 0);
    add(1, 0, 1, 0, 32'h33,           3, 32'h11, 0, 0);
    add(1, 0, 1, 0, 32'h44,           4, 32'h11, 0, 0);
    add(1, 0, 1, 0, 32'h55,           4, 32'h11, 1, 0); // overflow, dropped
    add(1, 0, 1, 1, 32'h66,           4, 32'h22, 1, 0); // push+pop at full
    add(1, 0, 0, 1, 32'h0,            3, 32'h33, 1, 0);
    add(1, 0, 0, 1, 32'h0,            2, 32'h44, 1, 0);
    add(1, 0, 0, 1, 32'h0,            1, 32'h66, 1, 0);
    add(1, 0, 0, 1, 32'h0,            0, INIT,   1, 0);
    add(1, 0, 0, 1, 32'h0,            0, INIT,   1, 1); // underflow
    add(1, 0, 1, 1, 32'h77,           1, 32'h77, 1, 1); // push+pop at empty
    add(1, 1, 0, 0, 32'h0,            0, INIT,   0, 0); // clr
    add(1, 0, 1, 0, 32'h01,           1, 32'h01, 0, 0);
    add(0, 0, 1, 0, 32'hAA,           1, 32'h01, 0, 0); // stalled
    add(0, 0, 1, 0, 32'hAA,           1, 32'h01, 0, 0);
    add(0, 0, 1, 0, 32'hAA,           1, 32'h01, 0, 0);
    add(0, 0, 0, 1, 32'h0,            1, 32'h01, 0, 0);
    add(1, 0, 1, 0, 32'h02,           2, 32'h01, 0, 0);
    add(1, 1, 1, 0, 32'h03,           0, INIT,   0, 0); // clr beats push
    add(1, 0, 1, 0, 32'h04,           1, 32'h04, 0, 0);
    add(1, 0, 0, 1, 32'h0,            0, INIT,   0, 0);
    add(1, 0, 1, 0, 32'h05,           1, 32'h05, 0, 0);
    add(0, 1, 0, 0, 32'h0,            0, INIT,   0, 0); // clr ignores enb

    for (int i = 0; i < vt.size(); i++) begin
      a_enb = vt[i].enb; a_clr = vt[i].clr; a_push = vt[i].push;
      a_pop = vt[i].pop; a_di = vt[i].di;
      @(posedge clk);
      #1;
      $display("a vec %0d: enb=%0d clr=%0d push=%0d pop=%0d di=%h -> cnt=%0d do=%h ovf=%0d udf=%0d",
               i, vt[i].enb, vt[i].clr, vt[i].push, vt[i].pop, vt[i].di,
               a_cnt, a_do, a_ovf, a_udf);
      chk_a($sformatf("vec%0d", i), vt[i].cnt, vt[i].dout, vt[i].ovf, vt[i].udf);
    end
    a_enb = 1'b0; a_clr = 1'b0; a_push = 1'b0; a_pop = 1'b0;

    // DEPTH=3: interleaved push/pop forcing several pointer wraps.
    chk("b_reset.empty", 32'(b_empty), 32'd1);
    step_b(1'b1, 1'b0, 32'hA0);
    step_b(1'b1, 1'b0, 32'hA1);
    for (int i = 0; i < 10; i++) begin
      step_b((i % 3) != 2, ((i % 2) == 1) || ((i % 3) == 2), 32'hB0 + 32'(i));
    end
    while (q.size() != 0) begin
      step_b(1'b0, 1'b1, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
